// File: rtl/bf_weight_ctrl_if.sv
// Coefficient write port, commit handshake and active-bank outputs of the beamformer weight controller.
interface bf_weight_ctrl_if;
    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_addr;
    logic signed [4:0] wr_data;
    logic              commit_req;
    logic              commit_busy;
    logic              commit_done;
    logic              shadow_dirty;
    logic              frame_sync;
    logic [39:0]       w_cos_1_o;
    logic [39:0]       w_sin_1_o;
    logic [39:0]       w_cos_2_o;
    logic [39:0]       w_sin_2_o;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_req,
        input  wr_ready, commit_busy, commit_done, shadow_dirty, frame_sync,
        input  w_cos_1_o, w_sin_1_o, w_cos_2_o, w_sin_2_o
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req,
        output wr_ready, commit_busy, commit_done, shadow_dirty, frame_sync,
        output w_cos_1_o, w_sin_1_o, w_cos_2_o, w_sin_2_o
    );
endinterface

// File: rtl/bf_weight_ctrl.sv
// Shadow/active weight banks: single-coefficient writes land in shadow, a commit copies shadow to active on LO frame wrap.
// Writes are refused (wr_ready=0) while a commit is pending or settling; commit_done pulses SETTLE_CYC clocks after the bank swap.
module bf_weight_ctrl #(
    parameter int unsigned       FRAME_LEN  = 4,
    parameter int unsigned       SETTLE_CYC = 6,
    parameter logic signed [4:0] W_RST_COS1 = 5'sd15
) (
    input  logic            clock,
    input  logic            reset,
    bf_weight_ctrl_if.slave bus
);
    localparam int FW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int SW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    // Bank index 0..3 = cos1, sin1, cos2, sin2; each bank holds 8 channels of 5 bits.
    typedef logic [3:0][7:0][4:0] bank_t;
    typedef enum logic [1:0] {IDLE, PEND, SETTLE} state_t;

    localparam bank_t BANK_RST = {120'd0, {8{W_RST_COS1}}};

    state_t        state_q, state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    bank_t         shadow_q, shadow_d;
    bank_t         active_q, active_d;
    logic          shadow_dirty_q, shadow_dirty_d;
    logic          commit_done_q, commit_done_d;

    logic wr_ready;
    logic commit_busy;
    logic boundary;
    logic wr_fire;
    logic commit_fire;
    logic settle_end;

    assign boundary    = (frame_cnt_q == FW'(FRAME_LEN - 1));
    assign wr_fire     = bus.wr_valid && wr_ready;
    assign commit_fire = (state_q == PEND) && boundary;
    assign settle_end  = (state_q == SETTLE) && (settle_cnt_q == SW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.commit_req) state_d = PEND;
            PEND:    if (boundary) state_d = (SETTLE_CYC == 0) ? IDLE : SETTLE;
            SETTLE:  if (settle_cnt_q == SW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready    = (state_q == IDLE);
        commit_busy = (state_q == PEND) || (state_q == SETTLE);
    end

    always_comb begin
        frame_cnt_d = boundary ? '0 : frame_cnt_q + 1'b1;

        settle_cnt_d = settle_cnt_q;
        if (commit_fire) begin
            settle_cnt_d = SW'(SETTLE_CYC);
        end else if ((state_q == SETTLE) && (settle_cnt_q != '0)) begin
            settle_cnt_d = settle_cnt_q - 1'b1;
        end

        shadow_d = shadow_q;
        if (wr_fire) begin
            shadow_d[bus.wr_addr[4:3]][bus.wr_addr[2:0]] = bus.wr_data;
        end

        // Writes are blocked outside IDLE, so the swap never races a shadow update.
        active_d = commit_fire ? shadow_q : active_q;

        shadow_dirty_d = shadow_dirty_q;
        if (wr_fire) begin
            shadow_dirty_d = 1'b1;
        end else if (commit_fire) begin
            shadow_dirty_d = 1'b0;
        end

        commit_done_d = settle_end || (commit_fire && (SETTLE_CYC == 0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q    <= '0;
            settle_cnt_q   <= '0;
            shadow_q       <= BANK_RST;
            active_q       <= BANK_RST;
            shadow_dirty_q <= 1'b0;
            commit_done_q  <= 1'b0;
        end else begin
            frame_cnt_q    <= frame_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            shadow_dirty_q <= shadow_dirty_d;
            commit_done_q  <= commit_done_d;
        end
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.commit_busy  = commit_busy;
    assign bus.commit_done  = commit_done_q;
    assign bus.shadow_dirty = shadow_dirty_q;
    assign bus.frame_sync   = (frame_cnt_q == '0);
    assign bus.w_cos_1_o    = active_q[0];
    assign bus.w_sin_1_o    = active_q[1];
    assign bus.w_cos_2_o    = active_q[2];
    assign bus.w_sin_2_o    = active_q[3];
endmodule

// File: tb/tb_bf_weight_ctrl.sv
// Bench for bf_weight_ctrl: one instance with SETTLE_CYC=6 and one with SETTLE_CYC=0, checked against a frame-arithmetic model.
module tb_bf_weight_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bf_weight_ctrl_if a ();
    bf_weight_ctrl_if b ();

    logic       use_b      = 1'b0;
    logic       wr_valid   = 1'b0;
    logic       commit_req = 1'b0;
    logic [4:0] wr_addr    = '0;
    logic [4:0] wr_data    = '0;

    assign a.wr_valid   = wr_valid && !use_b;
    assign a.commit_req = commit_req && !use_b;
    assign a.wr_addr    = wr_addr;
    assign a.wr_data    = wr_data;
    assign b.wr_valid   = wr_valid && use_b;
    assign b.commit_req = commit_req && use_b;
    assign b.wr_addr    = wr_addr;
    assign b.wr_data    = wr_data;

    bf_weight_ctrl #(.FRAME_LEN(4), .SETTLE_CYC(6), .W_RST_COS1(5'sd15)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a.slave)
    );

    bf_weight_ctrl #(.FRAME_LEN(4), .SETTLE_CYC(0), .W_RST_COS1(5'sd15)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b.slave)
    );

    wire o_ready = use_b ? b.wr_ready     : a.wr_ready;
    wire o_busy  = use_b ? b.commit_busy  : a.commit_busy;
    wire o_done  = use_b ? b.commit_done  : a.commit_done;
    wire o_dirty = use_b ? b.shadow_dirty : a.shadow_dirty;
    wire o_sync  = use_b ? b.frame_sync   : a.frame_sync;

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;

    // Reference model: banks as 40-bit words, channel k at [5k+4:5k].
    logic [39:0] m_sh  [4];
    logic [39:0] m_act [4];
    logic [39:0] m_new [4];
    logic [39:0] m_old [4];
    logic        m_dirty;

    function automatic logic [39:0] obs_bank(input int s);
        logic [39:0] r;
        case (s)
            0:       r = use_b ? b.w_cos_1_o : a.w_cos_1_o;
            1:       r = use_b ? b.w_sin_1_o : a.w_sin_1_o;
            2:       r = use_b ? b.w_cos_2_o : a.w_cos_2_o;
            default: r = use_b ? b.w_sin_2_o : a.w_sin_2_o;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_sh[s]  = (s == 0) ? {8{5'd15}} : 40'd0;
            m_act[s] = m_sh[s];
        end
        m_dirty = 1'b0;
    endtask

    task automatic mwrite(input logic [4:0] ad, input logic [4:0] dt);
        m_sh[ad[4:3]][5*ad[2:0] +: 5] = dt;
        m_dirty = 1'b1;
    endtask

    task automatic check_banks(input string tag);
        for (int s = 0; s < 4; s++) check($sformatf("%s_bank%0d", tag, s), obs_bank(s), m_act[s]);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        t++;
    endtask

    task automatic wait_frame(input int f);
        while (t % 4 != f) tick();
    endtask

    task automatic do_write(input logic [4:0] ad, input logic [4:0] dt);
        wr_valid = 1'b1;
        wr_addr  = ad;
        wr_data  = dt;
        check("wr_ready_idle", o_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        mwrite(ad, dt);
        check("dirty_after_wr", o_dirty, 1'b1);
        check_banks("active_hold");
    endtask

    // Commit issued now: PEND starts next cycle, swap on the first edge u>t0 where u%4==3,
    // new banks visible at u+1, commit_done visible at u+1+S.
    task automatic do_commit(input bit with_wr, input logic [4:0] swa, input logic [4:0] swd,
                             input bit hold_wr, input logic [4:0] hwa, input logic [4:0] hwd,
                             input bit repulse, input bit abort);
        int t0, u, S;
        logic dpre;
        S  = use_b ? 0 : 6;
        t0 = t;
        u  = t0 + 1;
        while (u % 4 != 3) u++;
        commit_req = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_addr  = swa;
            wr_data  = swd;
        end
        check("ready_at_req", o_ready, 1'b1);
        tick();
        commit_req = 1'b0;
        wr_valid   = 1'b0;
        if (with_wr) mwrite(swa, swd);
        for (int s = 0; s < 4; s++) begin
            m_old[s] = m_act[s];
            m_new[s] = m_sh[s];
        end
        dpre = m_dirty;
        if (hold_wr) begin
            wr_valid = 1'b1;
            wr_addr  = hwa;
            wr_data  = hwd;
        end
        if (repulse) commit_req = 1'b1;
        while (t <= u + 1 + S) begin
            check("busy", o_busy, (t <= u + S));
            check("done", o_done, (t == u + 1 + S));
            check("dirty", o_dirty, (t <= u) ? dpre : 1'b0);
            check("frame_sync", o_sync, (t % 4 == 0));
            for (int s = 0; s < 4; s++)
                check($sformatf("bank%0d", s), obs_bank(s), (t >= u + 1) ? m_new[s] : m_old[s]);
            if (hold_wr) check("wr_ready_hold", o_ready, !(t <= u + S));
            if (abort && t == u + 2) return;
            if (t == u + 1 + S) break;
            tick();
            commit_req = 1'b0;
        end
        for (int s = 0; s < 4; s++) m_act[s] = m_new[s];
        m_dirty = 1'b0;
        if (hold_wr) begin
            tick();
            wr_valid = 1'b0;
            mwrite(hwa, hwd);
            check("held_wr_accepted", o_dirty, 1'b1);
        end
        repeat (5) begin
            tick();
            check("quiet_busy", o_busy, 1'b0);
            check("quiet_done", o_done, 1'b0);
            check_banks("quiet");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] v;
        model_reset();

        // Reset state, held through two edges.
        repeat (2) @(posedge clock);
        #1;
        check_banks("in_reset");
        check("cos1_literal", a.w_cos_1_o, 40'h7BDEF7BDEF);
        reset = 1'b0;
        t = 0;

        for (int i = 0; i < 8; i++) begin
            check("rst_ready", o_ready, 1'b1);
            check("rst_busy", o_busy, 1'b0);
            check("rst_done", o_done, 1'b0);
            check("rst_dirty", o_dirty, 1'b0);
            check("rst_sync", o_sync, (t % 4 == 0));
            check("b_sync", b.frame_sync, (t % 4 == 0));
            check_banks("rst");
            tick();
        end
        check("b_cos1_rst", b.w_cos_1_o, 40'h7BDEF7BDEF);
        check("b_sin2_rst", b.w_sin_2_o, 40'd0);
        check("b_ready_rst", b.wr_ready, 1'b1);

        // Single write, commit requested at frame 1.
        do_write(5'b01_011, 5'h1C);
        wait_frame(1);
        do_commit(0, '0, '0, 0, '0, '0, 0, 0);
        v = obs_bank(1);
        check("sin1_ch3", v[19:15], 5'h1C);

        // Twenty random writes, no commit.
        for (int i = 0; i < 20; i++) do_write(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        // Writes held during busy, extra commit pulse in PEND.
        repeat ($urandom_range(0, 3)) tick();
        do_commit(0, '0, '0, 1, 5'd0, 5'd3, 1, 0);

        // Write in the same cycle as commit_req.
        do_commit(1, 5'b11_111, 5'h0A, 0, '0, '0, 0, 0);
        v = obs_bank(3);
        check("sin2_ch7", v[39:35], 5'h0A);
        v = obs_bank(0);
        check("cos1_ch0", v[4:0], 5'd3);

        // Commit with clean shadow.
        do_commit(0, '0, '0, 0, '0, '0, 0, 0);

        // Random write bursts and commits at random frame phases.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 5)) do_write(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3)) tick();
            do_commit(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0, '0, '0, 0, 0);
        end

        // Reset two cycles into SETTLE.
        do_write(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        do_commit(0, '0, '0, 0, '0, '0, 0, 1);
        reset = 1'b1;
        #1;
        model_reset();
        check_banks("abort");
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        check("abort_dirty", o_dirty, 1'b0);
        repeat (2) begin
            @(posedge clock);
            #1;
            check("done_in_reset", o_done, 1'b0);
        end
        reset = 1'b0;
        t = 0;
        check("sync_after_rst", o_sync, 1'b1);
        repeat (8) begin
            tick();
            check("post_abort_done", o_done, 1'b0);
        end

        // Zero settle time: done with the bank update.
        use_b = 1'b1;
        #1;
        check_banks("b_pre");
        do_write(5'b01_011, 5'h1C);
        wait_frame(1);
        do_commit(0, '0, '0, 0, '0, '0, 0, 0);
        v = obs_bank(1);
        check("b_sin1_ch3", v[19:15], 5'h1C);
        do_commit(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 5'd9, 5'd21, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
